mc_controller: RTL and testbench

Multicycle sequencing controller for the ARM-subset datapath. It holds the main state machine and the NZCV flag register, and evaluates instruction condition codes. It also decodes the ALU operation and waits out a configurable FPU latency. It drives every datapath control input (PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA/B, ResultSrc, ImmSrc, ALUControl) plus MemWrite to data memory, and sits between the instruction register and the datapath.

---
 rtl/mc_controller.sv | 207 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle sequencing controller: main FSM, NZCV flag register,
// condition-code evaluation, ALU op decode and FPU latency wait.
module mc_controller #(
  parameter int unsigned FPU_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic [3:0]  Flags,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_EXECUTEM = 4'd10,
    S_EXECUTEF = 4'd11,
    S_FPUWB    = 4'd12
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(FPU_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic [3:0] cnt_q, cnt_d;

  logic [1:0] op;
  logic       i_bit, s_bit, is_cmp, rd_pc, is_mul, cond_pass;
  logic [3:0] cmd, cond, alu_dec;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       unused_instr;

  assign op     = Instr[27:26];
  assign i_bit  = Instr[25];
  assign cmd    = Instr[24:21];
  assign s_bit  = Instr[20];
  assign cond   = Instr[31:28];
  assign is_cmp = (cmd == 4'b1010);
  assign rd_pc  = (Instr[15:12] == 4'hF);
  assign is_mul = (Instr[7:4] == 4'b1001);
  assign unused_instr = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};
  assign Flags  = flags_q;
  assign State  = state_q;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    alu_dec = 4'b0000;
    case (cmd)
      4'b0100: alu_dec = 4'b0000;
      4'b0010: alu_dec = 4'b0001;
      4'b0000: alu_dec = 4'b0010;
      4'b1100: alu_dec = 4'b0011;
      4'b1010: alu_dec = 4'b0001;
      default: alu_dec = 4'b0000;
    endcase
  end

  always_comb begin
    state_d    = S_FETCH;
    flags_d    = flags_q;
    cnt_d      = '0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 4'b0000;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (cond_pass) begin
          case (op)
            2'b00:   state_d = i_bit ? S_EXECUTEI : (is_mul ? S_EXECUTEM : S_EXECUTER);
            2'b01:   state_d = S_MEMADR;
            2'b10:   state_d = S_BRANCH;
            default: state_d = S_EXECUTEF;
          endcase
        end
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = s_bit ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        PCWrite   = rd_pc;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER, S_EXECUTEI: begin
        ALUSrcB    = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
        ALUControl = alu_dec;
        if (s_bit || is_cmp) flags_d = ALUFlags;
        state_d    = is_cmp ? S_FETCH : S_ALUWB;
      end
      S_EXECUTEM: begin
        ALUControl = 4'b0100;
        if (s_bit || is_cmp) flags_d = ALUFlags;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        PCWrite  = rd_pc;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_EXECUTEF: begin
        // Counter is zero on entry because every other state clears it.
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == CNT_LAST) ? S_FPUWB : S_EXECUTEF;
      end
      S_FPUWB: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Randomized self-checking bench for mc_controller against an
// instruction-level model (state path per instruction, per-state control table).
module tb_mc_controller;
  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [3:0]  ALUControl, Flags, State;
  logic [18:0] dut_ctrl;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic [3:0] flags_m = '0;
  int   seq[$];

  mc_controller #(.FPU_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .Flags(Flags), .State(State)
  );

  always #5 clk = ~clk;

  assign dut_ctrl = {PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA,
                     ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (instr %h)", tag, got, exp, Instr);
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v, r;
    {n, z, cc, v} = f;
    case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cc;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cc && !z;
      3'd5:    r = (n == v);
      3'd6:    r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !r : r;
  endfunction

  function automatic logic [3:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010: return 4'd1;
      4'b0000:          return 4'd2;
      4'b1100:          return 4'd3;
      default:          return 4'd0;
    endcase
  endfunction

  // Expected state path of one instruction given the current model flags.
  task automatic build_seq(input logic [31:0] ins);
    logic [1:0] op;
    op  = ins[27:26];
    seq = {0, 1};
    if (!cond_ok(ins[31:28], flags_m)) return;
    case (op)
      2'b00: begin
        if (!ins[25] && ins[7:4] == 4'b1001) seq = {seq, 10, 8};
        else begin
          seq.push_back(ins[25] ? 7 : 6);
          if (ins[24:21] != 4'b1010) seq.push_back(8);
        end
      end
      2'b01: seq = ins[20] ? {seq, 2, 3, 4} : {seq, 2, 5};
      2'b10: seq.push_back(9);
      default: begin
        for (int unsigned k = 0; k < LAT; k++) seq.push_back(11);
        seq.push_back(12);
      end
    endcase
  endtask

  function automatic logic [18:0] exp_ctrl(input int st, input logic [31:0] ins);
    logic pcw, rw, mw, irw, adr;
    logic [1:0] asa, asb, rs, op;
    logic [3:0] aluc;
    logic rd15;
    {pcw, rw, mw, irw, adr} = '0;
    asa = 2'd0; asb = 2'd0; rs = 2'd0; aluc = 4'd0;
    op   = ins[27:26];
    rd15 = (ins[15:12] == 4'hF);
    case (st)
      0:  begin irw = 1; pcw = 1; asa = 2'd1; asb = 2'd2; rs = 2'd2; end
      1:  begin asa = 2'd1; asb = 2'd2; rs = 2'd2; end
      2:  asb = 2'd1;
      3:  adr = 1;
      4:  begin rs = 2'd1; rw = 1; pcw = rd15; end
      5:  begin adr = 1; mw = 1; end
      6:  aluc = alu_of(ins[24:21]);
      7:  begin asb = 2'd1; aluc = alu_of(ins[24:21]); end
      8:  begin rw = 1; pcw = rd15; end
      9:  begin asb = 2'd1; rs = 2'd2; pcw = 1; end
      10: aluc = 4'd4;
      12: begin rs = 2'd3; rw = 1; end
      default: ;
    endcase
    return {pcw, rw, mw, irw, adr, asa, asb, rs, op,
            op == 2'b01, op == 2'b10, aluc};
  endfunction

  // Runs one instruction from FETCH; rst_at >= 0 asserts reset in that cycle.
  task automatic run_instr(input logic [31:0] ins, input bit force_f,
                           input logic [3:0] ff, input int rst_at);
    logic [18:0] exp;
    logic [3:0]  fl;
    bit          upd;
    build_seq(ins);
    foreach (seq[i]) begin
      Instr    = ins;
      fl       = force_f ? ff : 4'($urandom);
      ALUFlags = fl;
      if (i == rst_at) reset = 1'b1;
      @(negedge clk);
      check("state", 32'(State), 32'(seq[i]));
      exp = exp_ctrl(seq[i], ins);
      if (reset) exp[18:15] = '0;
      check("ctrl", 32'(dut_ctrl), 32'(exp));
      check("flags", 32'(Flags), 32'(flags_m));
      upd = (seq[i] == 6 || seq[i] == 7 || seq[i] == 10) &&
            (ins[20] || ins[24:21] == 4'b1010);
      @(posedge clk);
      #1;
      if (reset) begin
        reset   = 1'b0;
        flags_m = '0;
        check("rst_state", 32'(State), 32'd0);
        check("rst_flags", 32'(Flags), 32'd0);
        return;
      end
      if (upd) flags_m = fl;
    end
  endtask

  initial begin
    logic [31:0] ins;
    logic [3:0]  cmd;
    reset = 1'b1; Instr = '0; ALUFlags = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_state", 32'(State), 32'd0);
    check("reset_flags", 32'(Flags), 32'd0);
    check("reset_enables", 32'({PCWrite, RegWrite, MemWrite, IRWrite}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    flags_m = '0;

    run_instr(32'hE0821003, 1'b0, 4'h0, -1);   // ADD
    run_instr(32'hE5954004, 1'b0, 4'h0, -1);   // LDR
    run_instr(32'hE0500000, 1'b1, 4'b0100, -1); // SUBS
    check("subs_flags", 32'(Flags), 32'b0100);
    run_instr(32'h0A000002, 1'b0, 4'h0, -1);   // BEQ taken
    run_instr(32'h1A000002, 1'b0, 4'h0, -1);   // BNE not taken
    run_instr(32'hE0010392, 1'b0, 4'h0, -1);   // MUL
    run_instr(32'hF0010392, 1'b0, 4'h0, -1);   // never-condition MUL
    run_instr(32'hEE200A00, 1'b0, 4'h0, -1);   // FPU
    run_instr(32'hE0500000, 1'b1, 4'b1010, -1); // nonzero flags before reset
    run_instr(32'hE5854004, 1'b0, 4'h0, 3);    // STR, reset in MEMWRITE

    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 1) == 1) ins[31:28] = 4'hE;
      if (ins[27:26] == 2'b00 && !ins[25] && $urandom_range(0, 2) == 0) ins[7:4] = 4'b1001;
      case ($urandom_range(0, 5))
        0: cmd = 4'b0100;
        1: cmd = 4'b0010;
        2: cmd = 4'b0000;
        3: cmd = 4'b1100;
        4: cmd = 4'b1010;
        default: cmd = 4'($urandom);
      endcase
      ins[24:21] = cmd;
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
      run_instr(ins, 1'b0, 4'h0, ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 1)) : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
